// File: rtl/apb_uart_host_pkg.sv
// Shared definitions for the APB UART host: responder register map,
// FIFO_STATUS bit positions and the host sequencer state encoding.
package apb_uart_host_pkg;

    localparam logic [3:0] REG_DATA        = 4'h0;
    localparam logic [3:0] REG_FIFO_STATUS = 4'h4;
    localparam logic [3:0] REG_IRQ_STATUS  = 4'h8;
    localparam logic [3:0] REG_IRQ_ENABLE  = 4'hc;

    localparam int STAT_RX_AVAIL = 0;
    localparam int STAT_TX_SPACE = 1;

    typedef enum logic [2:0] {
        IDLE,
        ST_SETUP,
        ST_ACCESS,
        RD_SETUP,
        RD_ACCESS,
        WR_SETUP,
        WR_ACCESS,
        GAP
    } host_state_e;

    function automatic logic is_setup(input host_state_e s);
        return s inside {ST_SETUP, RD_SETUP, WR_SETUP};
    endfunction

    function automatic logic is_access(input host_state_e s);
        return s inside {ST_ACCESS, RD_ACCESS, WR_ACCESS};
    endfunction

endpackage

// File: rtl/apb_uart_host.sv
// APB initiator that polls a byte-UART responder, streams RX bytes out and
// pushes local TX bytes into the responder's FIFO.
module apb_uart_host
    import apb_uart_host_pkg::*;
#(
    parameter int POLL_GAP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [3:0]  PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        irq,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP);

    host_state_e r_state;
    host_state_e w_next_state;
    logic [7:0]  r_gap_cnt;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [3:0]  r_paddr;
    logic [7:0]  r_pwdata;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic        w_take_rx;
    logic        w_take_tx;
    logic        w_in_ready;
    logic        w_rd_done;
    logic        w_unused_prdata;

    // Only the low byte (data) and the two status flags are meaningful.
    assign w_unused_prdata = ^PRDATA[31:8];

    // RX wins only if the holding register is free, so no byte is ever dropped.
    assign w_take_rx = PRDATA[STAT_RX_AVAIL] && !r_out_valid;
    assign w_take_tx = PRDATA[STAT_TX_SPACE] && in_valid;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_rd_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_next_state = ST_SETUP;
            end
            ST_SETUP:  w_next_state = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    if (!enable) begin
                        w_next_state = IDLE;
                    end else if (w_take_rx) begin
                        w_next_state = RD_SETUP;
                    end else if (w_take_tx) begin
                        w_next_state = WR_SETUP;
                        w_in_ready   = 1'b1;
                    end else begin
                        w_next_state = GAP;
                    end
                end
            end
            RD_SETUP:  w_next_state = RD_ACCESS;
            RD_ACCESS: begin
                if (PREADY) begin
                    w_rd_done    = 1'b1;
                    w_next_state = enable ? ST_SETUP : IDLE;
                end
            end
            WR_SETUP:  w_next_state = WR_ACCESS;
            WR_ACCESS: begin
                if (PREADY) w_next_state = enable ? ST_SETUP : IDLE;
            end
            GAP: begin
                if (!enable) begin
                    w_next_state = IDLE;
                end else if (irq || r_gap_cnt <= 8'd1) begin
                    w_next_state = ST_SETUP;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_gap_cnt <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_ACCESS && w_next_state == GAP) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_state == GAP && r_gap_cnt != 8'd0) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end
        end
    end

    // APB outputs are flops driven from the next state, so they line up with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= 4'h0;
            r_pwdata  <= 8'h00;
        end else begin
            r_psel    <= is_setup(w_next_state) || is_access(w_next_state);
            r_penable <= is_access(w_next_state);
            case (w_next_state)
                ST_SETUP: begin
                    r_paddr  <= REG_FIFO_STATUS;
                    r_pwrite <= 1'b0;
                end
                RD_SETUP: begin
                    r_paddr  <= REG_DATA;
                    r_pwrite <= 1'b0;
                end
                WR_SETUP: begin
                    r_paddr  <= REG_DATA;
                    r_pwrite <= 1'b1;
                end
                default: ;
            endcase
            if (w_in_ready) r_pwdata <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
        end else if (w_rd_done) begin
            r_out_valid <= 1'b1;
            r_out_data  <= PRDATA[7:0];
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = {24'h0, r_pwdata};
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_apb_uart_host.sv
// Self-checking bench for apb_uart_host: vector table, directed corner cases
// and a randomized run checked against a transaction-level byte model.
module tb_apb_uart_host;

    localparam int POLL_GAP = 4;
    localparam int K_NONE   = 0;
    localparam int K_STATUS = 1;
    localparam int K_READ   = 2;
    localparam int K_WRITE  = 3;
    localparam int K_BAD    = 4;

    typedef struct {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [3:0]  paddr;
        logic [31:0] pwdata;
        logic [31:0] prdata;
        logic        pready;
        logic        in_ready;
        logic        in_valid;
        logic [7:0]  in_data;
        logic        out_valid;
        logic [7:0]  out_data;
        logic        out_ready;
    } obs_t;

    typedef struct {
        logic [31:0] status;
        logic [7:0]  data;
        logic        in_valid;
        logic [7:0]  in_data;
        logic        out_ready;
        int          exp_kind;
        int          exp_gap;
        logic        exp_in_ready;
        logic        exp_ov4;
        logic        exp_ov5;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        irq;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    logic        pready_rand;
    logic [31:0] status_word;
    logic [31:0] data_word;
    int          stall_left;

    obs_t log_q[$];
    int   n_vec;
    int   n_err;

    apb_uart_host #(.POLL_GAP(POLL_GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .irq       (irq),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Responder model: status at 0x4, data at 0x0, optional wait states on DATA.
    assign PREADY = pready_rand && !(PSEL && PENABLE && PADDR == 4'h0 && stall_left != 0);
    assign PRDATA = (PADDR == 4'h4) ? status_word
                  : ((stall_left != 0) ? 32'h0000_0011 : data_word);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        obs_t o;
        #1;
        o.psel      = PSEL;
        o.penable   = PENABLE;
        o.pwrite    = PWRITE;
        o.paddr     = PADDR;
        o.pwdata    = PWDATA;
        o.prdata    = PRDATA;
        o.pready    = PREADY;
        o.in_ready  = in_ready;
        o.in_valid  = in_valid;
        o.in_data   = in_data;
        o.out_valid = out_valid;
        o.out_data  = out_data;
        o.out_ready = out_ready;
        log_q.push_back(o);
        @(negedge clk);
        if (o.psel && o.penable && o.paddr == 4'h0 && stall_left != 0) stall_left--;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        enable      = 1'b0;
        irq         = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b0;
        pready_rand = 1'b1;
        status_word = 32'h0;
        data_word   = 32'h0;
        stall_left  = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        log_q.delete();
    endtask

    function automatic int kind_of(input obs_t o);
        if (!o.psel) return K_NONE;
        if (o.paddr == 4'h4 && !o.pwrite) return K_STATUS;
        if (o.paddr == 4'h0 && !o.pwrite) return K_READ;
        if (o.paddr == 4'h0 && o.pwrite) return K_WRITE;
        return K_BAD;
    endfunction

    function automatic logic is_setup_obs(input obs_t o);
        return o.psel && !o.penable;
    endfunction

    function automatic logic done_obs(input obs_t o);
        return o.psel && o.penable && o.pready;
    endfunction

    function automatic int find_setup(input int from);
        for (int i = from; i < log_q.size(); i++) begin
            if (is_setup_obs(log_q[i])) return i;
        end
        return -1;
    endfunction

    vec_t vecs[8];

    task automatic run_table();
        vec_t v;
        int   s;
        int   nx;
        vecs[0] = '{32'h0000_0000, 8'h5A, 1'b0, 8'h00, 1'b1, K_STATUS, POLL_GAP, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0001, 8'h5A, 1'b0, 8'h00, 1'b1, K_READ,   0,        1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0002, 8'h00, 1'b1, 8'hA5, 1'b1, K_WRITE,  0,        1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0003, 8'h3C, 1'b1, 8'hA5, 1'b0, K_READ,   0,        1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_0002, 8'h00, 1'b0, 8'h77, 1'b1, K_STATUS, POLL_GAP, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFC, 8'h5A, 1'b1, 8'h12, 1'b1, K_STATUS, POLL_GAP, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h8000_0002, 8'h00, 1'b1, 8'h3C, 1'b0, K_WRITE,  0,        1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0001, 8'h80, 1'b0, 8'h00, 1'b0, K_READ,   0,        1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            do_reset();
            status_word = v.status;
            data_word   = {24'hABCDEF, v.data};
            in_valid    = v.in_valid;
            in_data     = v.in_data;
            out_ready   = v.out_ready;
            enable      = 1'b1;
            repeat (14) step();
            s = find_setup(0);
            check($sformatf("tbl%0d_first_setup_cycle", i), 32'(s), 32'd1);
            if (s >= 0) begin
                check($sformatf("tbl%0d_first_is_status", i), 32'(kind_of(log_q[s])), 32'(K_STATUS));
                check($sformatf("tbl%0d_in_ready", i), 32'(log_q[s+1].in_ready), 32'(v.exp_in_ready));
                nx = find_setup(s + 2);
                check($sformatf("tbl%0d_next_gap", i), 32'(nx - s - 2), 32'(v.exp_gap));
                if (nx >= 0) begin
                    check($sformatf("tbl%0d_next_kind", i), 32'(kind_of(log_q[nx])), 32'(v.exp_kind));
                    if (v.exp_kind == K_WRITE) begin
                        check($sformatf("tbl%0d_pwdata", i), log_q[nx].pwdata, {24'h0, v.in_data});
                        check($sformatf("tbl%0d_pwdata_access", i), log_q[nx+1].pwdata, {24'h0, v.in_data});
                    end
                end
                check($sformatf("tbl%0d_out_valid_5th", i), 32'(log_q[s+4].out_valid), 32'(v.exp_ov4));
                if (v.exp_ov4) begin
                    check($sformatf("tbl%0d_out_data", i), 32'(log_q[s+4].out_data), 32'(v.data));
                end
                check($sformatf("tbl%0d_out_valid_6th", i), 32'(log_q[s+5].out_valid), 32'(v.exp_ov5));
            end
        end
    endtask

    task automatic seq_idle_poll();
        int n_data;
        int n_status;
        int n_ir;
        int n_ov;
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        repeat (40) step();
        n_data = 0; n_status = 0; n_ir = 0; n_ov = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].psel && log_q[i].paddr == 4'h0) n_data++;
            if (is_setup_obs(log_q[i]) && kind_of(log_q[i]) == K_STATUS) n_status++;
            if (log_q[i].in_ready) n_ir++;
            if (log_q[i].out_valid) n_ov++;
        end
        check("idle_no_data_access", 32'(n_data), 32'd0);
        check("idle_status_polls", 32'(n_status), 32'((40 - 1 + POLL_GAP + 1) / (POLL_GAP + 2)));
        check("idle_no_in_ready", 32'(n_ir), 32'd0);
        check("idle_no_out_valid", 32'(n_ov), 32'd0);
    endtask

    task automatic seq_rx_priority();
        int   n_rd;
        logic saw_wr;
        do_reset();
        status_word = 32'h3;
        data_word   = 32'h5A;
        in_valid    = 1'b1;
        in_data     = 8'hA5;
        enable      = 1'b1;
        repeat (24) step();
        n_rd = 0; saw_wr = 1'b0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (done_obs(log_q[i]) && kind_of(log_q[i]) == K_READ) n_rd++;
            if (is_setup_obs(log_q[i]) && kind_of(log_q[i]) == K_WRITE && log_q[i].pwdata == 32'hA5) saw_wr = 1'b1;
        end
        check("prio_first_decision_no_in_ready", 32'(log_q[2].in_ready), 32'd0);
        check("prio_single_read", 32'(n_rd), 32'd1);
        check("prio_write_issued", 32'(saw_wr), 32'd1);
        check("prio_out_valid_held", 32'(log_q[$].out_valid), 32'd1);
        check("prio_out_data_held", 32'(log_q[$].out_data), 32'h5A);
    endtask

    task automatic seq_wait_states();
        int   a;
        obs_t o;
        do_reset();
        status_word = 32'h1;
        data_word   = 32'h77;
        stall_left  = 3;
        enable      = 1'b1;
        repeat (12) step();
        a = -1;
        for (int i = 0; i < log_q.size() && a < 0; i++) begin
            if (log_q[i].psel && log_q[i].penable && kind_of(log_q[i]) == K_READ) a = i;
        end
        check("wait_rd_access_found", 32'(a >= 0), 32'd1);
        if (a >= 0) begin
            for (int k = 1; k < 4; k++) begin
                o = log_q[a+k];
                check($sformatf("wait_stable_%0d", k),
                      {25'h0, o.psel, o.penable, o.pwrite, o.paddr},
                      {25'h0, 1'b1, 1'b1, 1'b0, 4'h0});
                check($sformatf("wait_out_valid_low_%0d", k), 32'(o.out_valid), 32'd0);
            end
            check("wait_pready_low_first", 32'(log_q[a].pready), 32'd0);
            check("wait_pready_high_last", 32'(log_q[a+3].pready), 32'd1);
            check("wait_out_valid", 32'(log_q[a+4].out_valid), 32'd1);
            check("wait_out_data", 32'(log_q[a+4].out_data), 32'h77);
        end
    endtask

    task automatic seq_reset_mid_write();
        logic found;
        int   base;
        int   n_bad;
        do_reset();
        status_word = 32'h2;
        in_valid    = 1'b1;
        in_data     = 8'hA5;
        out_ready   = 1'b1;
        stall_left  = 5;
        enable      = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (log_q[$].psel && log_q[$].penable && log_q[$].pwrite) found = 1'b1;
        end
        check("rst_wr_access_reached", 32'(found), 32'd1);
        if (found) begin
            reset = 1'b0;
            #1;
            check("rst_psel_immediate", 32'(PSEL), 32'd0);
            check("rst_penable_immediate", 32'(PENABLE), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            stall_left = 0;
            enable = 1'b0;
            base = log_q.size();
            repeat (2) step();
            reset = 1'b1;
            repeat (4) step();
            n_bad = 0;
            for (int i = base; i < log_q.size(); i++) begin
                if (log_q[i].psel || log_q[i].in_ready) n_bad++;
            end
            check("rst_quiet_after", 32'(n_bad), 32'd0);
        end
    endtask

    task automatic seq_irq_gap();
        logic found;
        int   c;
        do_reset();
        enable = 1'b1;
        found = 1'b0;
        c = -1;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (done_obs(log_q[$]) && kind_of(log_q[$]) == K_STATUS) begin
                found = 1'b1;
                c = log_q.size() - 1;
            end
        end
        check("irq_status_done_found", 32'(found), 32'd1);
        if (found) begin
            irq = 1'b1;
            step();
            irq = 1'b0;
            step();
            check("irq_gap_cycle_idle", 32'(log_q[c+1].psel), 32'd0);
            check("irq_next_setup_cycle", 32'(find_setup(c + 1)), 32'(c + 2));
            check("irq_next_is_status", 32'(kind_of(log_q[c+2])), 32'(K_STATUS));
        end
    endtask

    task automatic seq_enable_drop();
        logic found;
        int   base;
        int   n_bad;
        do_reset();
        status_word = 32'h2;
        in_valid    = 1'b1;
        in_data     = 8'h3C;
        enable      = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (is_setup_obs(log_q[$]) && kind_of(log_q[$]) == K_STATUS) found = 1'b1;
        end
        check("endrop_setup_found", 32'(found), 32'd1);
        if (found) begin
            enable = 1'b0;
            step();
            check("endrop_status_completes", 32'(done_obs(log_q[$])), 32'd1);
            check("endrop_no_in_ready", 32'(log_q[$].in_ready), 32'd0);
            base = log_q.size();
            repeat (4) step();
            n_bad = 0;
            for (int i = base; i < log_q.size(); i++) begin
                if (log_q[i].psel || log_q[i].in_ready) n_bad++;
            end
            check("endrop_parked", 32'(n_bad), 32'd0);
        end
    endtask

    task automatic run_random();
        logic [7:0] tx_q[$];
        logic [7:0] rx_q[$];
        obs_t       o;
        obs_t       p;
        logic       hs_last;
        logic       pending;
        int         exp_at;
        int         exp_kind;
        logic       exp_ir;
        logic       take_rd;
        logic       take_wr;
        int         idx;
        do_reset();
        enable  = 1'b1;
        hs_last = 1'b0;
        pending = 1'b0;
        exp_at  = 0;
        exp_kind = K_NONE;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            pready_rand = ($urandom_range(3) != 0);
            status_word = $urandom();
            data_word   = $urandom();
            if (!in_valid || hs_last) begin
                in_valid = 1'($urandom_range(1));
                in_data  = 8'($urandom());
            end
            out_ready = 1'($urandom_range(1));
            step();
            idx = log_q.size() - 1;
            o = log_q[idx];
            hs_last = o.in_valid && o.in_ready;

            // A byte may be offered only at a status completion that found TX room and no RX to take.
            take_rd = o.prdata[0] && !o.out_valid;
            take_wr = !take_rd && o.prdata[1] && o.in_valid;
            exp_ir  = done_obs(o) && kind_of(o) == K_STATUS && take_wr;
            check("rnd_in_ready", 32'(o.in_ready), 32'(exp_ir));
            if (hs_last) tx_q.push_back(o.in_data);

            if (done_obs(o) && kind_of(o) == K_WRITE) begin
                check("rnd_tx_queue_nonempty", 32'(tx_q.size() != 0), 32'd1);
                if (tx_q.size() != 0) check("rnd_pwdata", o.pwdata, {24'h0, tx_q.pop_front()});
            end
            if (done_obs(o) && kind_of(o) == K_READ) begin
                check("rnd_read_into_empty_holder", 32'(o.out_valid), 32'd0);
                rx_q.push_back(o.prdata[7:0]);
            end
            if (o.out_valid && o.out_ready) begin
                check("rnd_rx_queue_nonempty", 32'(rx_q.size() != 0), 32'd1);
                if (rx_q.size() != 0) check("rnd_out_data", 32'(o.out_data), 32'(rx_q.pop_front()));
            end

            if (is_setup_obs(o) && pending) begin
                check("rnd_next_setup_cycle", 32'(idx), 32'(exp_at));
                check("rnd_next_kind", 32'(kind_of(o)), 32'(exp_kind));
                pending = 1'b0;
            end
            if (done_obs(o)) begin
                pending = 1'b1;
                if (kind_of(o) == K_STATUS) begin
                    exp_kind = take_rd ? K_READ : (take_wr ? K_WRITE : K_STATUS);
                    exp_at   = idx + 1 + ((take_rd || take_wr) ? 0 : POLL_GAP);
                end else begin
                    exp_kind = K_STATUS;
                    exp_at   = idx + 1;
                end
            end

            if (idx > 0) begin
                p = log_q[idx-1];
                if ((p.psel && p.penable && !p.pready) || is_setup_obs(p)) begin
                    check("rnd_access_stable",
                          {1'b0, o.psel, o.penable, o.pwrite, o.paddr, o.pwdata[7:0], 16'h0},
                          {1'b0, 1'b1, 1'b1, p.pwrite, p.paddr, p.pwdata[7:0], 16'h0});
                end
            end
        end
        check("rnd_rx_backlog", 32'(rx_q.size() <= 1), 32'd1);
        check("rnd_tx_backlog", 32'(tx_q.size() <= 1), 32'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset       = 1'b0;
        enable      = 1'b1;
        irq         = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'hFF;
        out_ready   = 1'b0;
        pready_rand = 1'b1;
        status_word = 32'h3;
        data_word   = 32'hFF;
        stall_left  = 0;
        repeat (3) @(negedge clk);
        check("reset_apb_outputs", {PSEL, PENABLE, PWRITE, PADDR}, 32'h0);
        check("reset_pwdata", PWDATA, 32'h0);
        check("reset_out_stream", {out_valid, out_data}, 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'd0);

        do_reset();
        repeat (4) step();
        check("idle_stays_quiet", 32'(find_setup(0)), 32'hFFFF_FFFF);

        run_table();
        seq_idle_poll();
        seq_rx_priority();
        seq_wait_states();
        seq_reset_mid_write();
        seq_irq_gap();
        seq_enable_drop();
        run_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_uart_host.md
Name: apb_uart_host

Overview:
- APB initiator that services an APB byte-UART register block (DATA 0x0, FIFO_STATUS 0x4) from the requester side.
- Polls FIFO_STATUS, reads RX bytes into a local output byte stream, and writes bytes from a local input byte stream into the TX FIFO.
- Sits between a local byte-stream client (debug bridge, loader, loopback) and a UART-style APB responder on the same APB segment.
- Honours PREADY wait states.

Parameters:
POLL_GAP, 4, idle cycles between status polls when no transfer was possible (1..255)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
enable  input  1  run polling; low = finish current APB transfer, then park in IDLE
PSEL  output  1  APB select
PENABLE  output  1  APB enable (access phase)
PWRITE  output  1  APB write
PADDR  output  4  APB address (only 0x0 and 0x4 are used)
PWDATA  output  32  APB write data, {24'h0, byte}
PRDATA  input  32  APB read data
PREADY  input  1  APB responder ready; low extends the access phase
irq  input  1  UART IRQ level; cuts the poll gap short
in_data  input  8  byte to transmit
in_valid  input  1  in_data valid
in_ready  output  1  in_data accepted this cycle (combinational)
out_data  output  8  received byte
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset (reset==0, async):
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - out_valid=0, out_data=0, gap counter=0, state=IDLE.
  - Reset during an access drops PSEL immediately; the transfer is abandoned and no byte is consumed or produced.
- All APB outputs are registered. in_ready is the only combinational output.
- FSM states: IDLE, ST_SETUP, ST_ACCESS, RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS, GAP.
- IDLE: APB quiet. When enable=1, next state is ST_SETUP.
- SETUP states:
  - PSEL=1, PENABLE=0, PWRITE/PADDR/PWDATA set for the transfer.
  - ST uses PADDR=0x4, write=0. RD uses 0x0, write=0. WR uses 0x0, write=1.
  - Always exactly one cycle, then the matching ACCESS state.
- ACCESS states:
  - PSEL=1, PENABLE=1.
  - PADDR, PWRITE and PWDATA stay stable until the cycle with PREADY=1.
  - PSEL and PENABLE fall on the edge after completion unless the next state is a SETUP state. Back-to-back transfers keep PSEL=1 with PENABLE=0.
- ST_ACCESS completion (PREADY=1): decide from PRDATA bit0 (rx_avail), PRDATA bit1 (tx_space), in_valid and out_valid.
  - rx_avail && !out_valid -> RD_SETUP. RX has priority over TX.
  - else tx_space && in_valid -> WR_SETUP. in_ready=1 this cycle and in_data is latched into PWDATA[7:0].
  - else -> GAP, with the gap counter loaded to POLL_GAP.
  - If enable=0 at completion -> IDLE, with no in_ready.
- RD_ACCESS completion: PRDATA[7:0] -> out_data and out_valid=1 on the next edge. Next state is ST_SETUP, or IDLE if enable=0.
- WR_ACCESS completion: next state is ST_SETUP, or IDLE if enable=0. The byte was already consumed at its handshake.
- GAP:
  - Counter decrements each cycle.
  - Leaves to ST_SETUP when the counter reaches 1, or immediately when irq=1.
  - Goes to IDLE if enable=0.
- Output stream: single holding register.
  - out_valid clears on the edge where out_valid && out_ready.
  - A new RX read is only issued when the holding register is empty at the decision cycle, so no byte is ever dropped.
- in_ready is never asserted outside the ST_ACCESS completion cycle. Each accepted byte produces exactly one APB write.
- Latency, PREADY=1 throughout:
  - Poll to out_valid = 5 cycles: ST_SETUP, ST_ACCESS, RD_SETUP, RD_ACCESS, then the register edge.
  - in handshake to write completion = 2 cycles.
- Bits of PRDATA other than those used are ignored.

Decomposition:
- Shared package holds:
  - UART register offset constants (DATA=4'h0, FIFO_STATUS=4'h4, IRQ_STATUS=4'h8, IRQ_ENABLE=4'hc).
  - FIFO_STATUS bit indices (RX_AVAIL=0, TX_SPACE=1).
  - FSM state encoding.
- Optional sub-module apb_req_phase: generic SETUP/ACCESS sequencer. The host FSM then only chooses addr/write/data. A single flat module is also acceptable.

Test Plan:
- Reset then enable=1, status always reads 0x00, PREADY=1 -> repeating pattern: one read of 0x4, then a gap of POLL_GAP(4) cycles. No access to 0x0; in_ready and out_valid stay 0.
- Status 0x01, DATA reads 0x5A, out_ready=1 -> a read of 0x4 then a read of 0x0; out_valid=1 with out_data=0x5A exactly 5 cycles after the first SETUP, for one cycle.
- Status 0x02, in_valid=1, in_data=0xA5 -> in_ready pulses once in the status completion cycle; the next transfer is a write of 0x0 with PWDATA=0x000000A5.
- Status 0x03, in_valid=1, out_ready=0 -> first byte is read (RX priority). On the next poll out_valid is still 1, so the block writes 0xA5 instead of reading; no RX byte is lost.
- PREADY held low 3 cycles in RD_ACCESS -> PADDR, PWRITE and PENABLE remain stable; data is captured only on the PREADY=1 cycle.
- reset asserted mid WR_ACCESS -> PSEL=0 immediately, no further in_ready. irq=1 in GAP -> the next cycle is ST_SETUP.
